rdata_packer: RTL and testbench

//  Read-path counterpart of the write-data FIFO: collects 16-bit half-words from the HyperBus read

---
 rtl/rpack_pkg.sv | 31 +++
 rtl/rpack_sfifo.sv | 64 ++++++
 rtl/rdata_packer.sv | 170 +++++++++++++++++
 tb/tb_rdata_packer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpack_pkg.sv
// -----------------------------------------------------------------------------
// rpack_pkg
// Shared definitions for the HyperBus read-data packer.
//   HWORD_W        width of one memory-side half-word (16)
//   lanes(width)   number of 16-bit lanes in an output word
//   ptr_w(depth)   FIFO pointer width: one wrap bit above the address bits
//   rpack_entry_t  FIFO entry layout {last, keep, data} at the widest legal
//                  bus (64 bits, 4 lanes). Narrower builds keep the same field
//                  order and use only the low lanes.
// -----------------------------------------------------------------------------
package rpack_pkg;

  localparam int HWORD_W   = 16;
  localparam int MAX_BUS_W = 64;
  localparam int MAX_LANES = MAX_BUS_W / HWORD_W;

  function automatic int lanes(input int width);
    return width / HWORD_W;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic                 last;
    logic [MAX_LANES-1:0] keep;
    logic [MAX_BUS_W-1:0] data;
  } rpack_entry_t;

endpackage

// File: rtl/rpack_sfifo.sv
// -----------------------------------------------------------------------------
// rpack_sfifo
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on o_pop_data; o_empty low means it is valid.
// Ports:
//   clk, arstn     clock, asynchronous active-low reset (pointers only)
//   i_push         write i_push_data (ignored while full)
//   i_pop          retire the head entry (ignored while empty)
//   o_pop_data     head entry
//   o_full/o_empty status from the extended-pointer compare
//   o_count        number of stored entries (0..DEPTH)
// The storage array is not reset; its contents are don't-care while empty.
// -----------------------------------------------------------------------------
module rpack_sfifo
  import rpack_pkg::*;
#(
  parameter int ENTRY_W = 35,
  parameter int DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic                    i_push,
  input  logic [ENTRY_W-1:0]      i_push_data,
  input  logic                    i_pop,
  output logic [ENTRY_W-1:0]      o_pop_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ptr_w(DEPTH)-1:0] o_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  // Same address bits with differing wrap bits means the writer is a full lap ahead.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_push  = i_push & ~o_full;
  assign w_do_pop   = i_pop  & ~o_empty;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/rdata_packer.sv
// -----------------------------------------------------------------------------
// rdata_packer
// Packs 16-bit read half-words from the HyperBus datapath into
// DATA_BUS_WIDTH-bit words for the AXI read channel. The first half-word of a
// word lands in bits [15:0]. A burst that ends mid-word is flushed as a partial
// word whose unfilled lanes read 0 with their keep bits cleared.
//
// Parameters: DATA_BUS_WIDTH (16/32/64), FIFO_DEPTH (power of two, >= 2).
// Ports:
//   clk, arstn         memory clock, asynchronous active-low reset
//   in_data/in_valid   half-word stream; the source cannot stall
//   in_last            closes the burst (qualified by in_valid)
//   in_ready           room in the word buffer (from the registered count)
//   ovf_err, ovf_clr   sticky drop flag and its synchronous clear
//   out_data/out_keep/out_last/out_valid/out_ready   packed-word stream
//   fifo_level, ovf_cnt   only with RPACK_STATUS_EN defined
//
// Handshakes: a half-word is taken on a cycle with in_valid & in_ready; with
// in_valid & !in_ready it is dropped. A word moves on a cycle with
// out_valid & out_ready; while out_valid & !out_ready all out_* hold steady.
//
// Configuration macro RPACK_STATUS_EN adds fifo_level and a saturating drop
// counter ovf_cnt (also zeroed by ovf_clr). Core behaviour is unchanged.
// -----------------------------------------------------------------------------
module rdata_packer
  import rpack_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [15:0]                   in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          ovf_err,
  input  logic                          ovf_clr,
  output logic [DATA_BUS_WIDTH-1:0]     out_data,
  output logic [DATA_BUS_WIDTH/16-1:0]  out_keep,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef RPACK_STATUS_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    ovf_cnt
`endif
);

  localparam int N  = lanes(DATA_BUS_WIDTH);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int EW = 1 + N + DATA_BUS_WIDTH;

  if (!(DATA_BUS_WIDTH == 16 || DATA_BUS_WIDTH == 32 || DATA_BUS_WIDTH == 64)) begin : g_bad_width
    $error("rdata_packer: DATA_BUS_WIDTH must be 16, 32 or 64");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rdata_packer: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic                      last;
    logic [N-1:0]              keep;
    logic [DATA_BUS_WIDTH-1:0] data;
  } entry_t;

  // Packer state: lane counter plus partially assembled word.
  logic [LW-1:0]             r_lane_idx;
  logic [DATA_BUS_WIDTH-1:0] r_asm_data;
  logic [N-1:0]              r_asm_keep;
  logic                      r_ovf_err;

  logic                      w_accept;
  logic                      w_drop;
  logic                      w_close;
  logic                      w_full;
  logic                      w_empty;
  logic [PW-1:0]             w_count;
  logic [DATA_BUS_WIDTH-1:0] w_word;
  logic [N-1:0]              w_keep;
  entry_t                    w_push_entry;
  entry_t                    w_pop_entry;

  assign in_ready = (w_count < PW'(FIFO_DEPTH));
  assign w_accept = in_valid & in_ready;
  assign w_drop   = in_valid & w_full;
  assign w_close  = w_accept & ((r_lane_idx == LW'(N - 1)) | in_last);

  // Current assembly with the incoming half-word merged into its lane.
  always_comb begin
    w_word = r_asm_data;
    w_keep = r_asm_keep;
    w_word[r_lane_idx*HWORD_W +: HWORD_W] = in_data;
    w_keep[r_lane_idx] = 1'b1;
  end

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.last = in_last;
    w_push_entry.keep = w_keep;
    w_push_entry.data = w_word;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_lane_idx <= '0;
      r_asm_data <= '0;
      r_asm_keep <= '0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          // Word leaves for the FIFO this cycle; start the next one clean.
          r_lane_idx <= '0;
          r_asm_data <= '0;
          r_asm_keep <= '0;
        end else begin
          r_lane_idx <= r_lane_idx + 1'b1;
          r_asm_data <= w_word;
          r_asm_keep <= w_keep;
        end
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)       r_ovf_err <= 1'b1;
      else if (ovf_clr) r_ovf_err <= 1'b0;
    end
  end

  rpack_sfifo #(
    .ENTRY_W (EW),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .arstn       (arstn),
    .i_push      (w_close),
    .i_push_data (w_push_entry),
    .i_pop       (out_valid & out_ready),
    .o_pop_data  (w_pop_entry),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign ovf_err   = r_ovf_err;
  assign out_valid = ~w_empty;
  assign out_data  = w_pop_entry.data;
  // Keep/last are forced low while nothing is buffered so they read 0 after reset.
  assign out_keep  = w_empty ? '0 : w_pop_entry.keep;
  assign out_last  = ~w_empty & w_pop_entry.last;

`ifdef RPACK_STATUS_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_ovf_cnt <= 8'd0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= {7'd0, w_drop};
    end else if (w_drop && r_ovf_cnt != 8'hFF) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_cnt    = r_ovf_cnt;
  assign fifo_level = w_count;
`endif

endmodule

// File: tb/tb_rdata_packer.sv
// -----------------------------------------------------------------------------
// tb_rdata_packer
// Three packer instances share one clock:
//   u_a  DATA_BUS_WIDTH=32, FIFO_DEPTH=4
//   u_b  DATA_BUS_WIDTH=64, FIFO_DEPTH=16
//   u_c  DATA_BUS_WIDTH=16, FIFO_DEPTH=4
// Drivers push the expected {last, keep, data} into a per-instance queue when
// they issue the completing half-word; a monitor per instance pops and compares
// on every out_valid & out_ready cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_rdata_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A: 32-bit, depth 4 ----------------
  logic        a_arstn, a_in_valid, a_in_last, a_in_ready, a_ovf_err, a_ovf_clr;
  logic [15:0] a_in_data;
  logic [31:0] a_out_data;
  logic [1:0]  a_out_keep;
  logic        a_out_last, a_out_valid, a_out_ready;
  logic [2:0]  a_fifo_level;
  logic [7:0]  a_ovf_cnt;
  logic [34:0] a_exp_q[$];
  logic [34:0] a_exp;

  // ---------------- instance B: 64-bit, depth 16 ----------------
  logic        b_arstn, b_in_valid, b_in_last, b_in_ready, b_ovf_err, b_ovf_clr;
  logic [15:0] b_in_data;
  logic [63:0] b_out_data;
  logic [3:0]  b_out_keep;
  logic        b_out_last, b_out_valid, b_out_ready;
  logic [4:0]  b_fifo_level;
  logic [7:0]  b_ovf_cnt;
  logic [68:0] b_exp_q[$];
  logic [68:0] b_exp;

  // ---------------- instance C: 16-bit, depth 4 ----------------
  logic        c_arstn, c_in_valid, c_in_last, c_in_ready, c_ovf_err, c_ovf_clr;
  logic [15:0] c_in_data;
  logic [15:0] c_out_data;
  logic [0:0]  c_out_keep;
  logic        c_out_last, c_out_valid, c_out_ready;
  logic [2:0]  c_fifo_level;
  logic [7:0]  c_ovf_cnt;
  logic [17:0] c_exp_q[$];
  logic [17:0] c_exp;

  logic drv_done;

  rdata_packer #(.DATA_BUS_WIDTH(32), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .arstn(a_arstn), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_last(a_in_last), .in_ready(a_in_ready), .ovf_err(a_ovf_err), .ovf_clr(a_ovf_clr),
    .out_data(a_out_data), .out_keep(a_out_keep), .out_last(a_out_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef RPACK_STATUS_EN
    , .fifo_level(a_fifo_level), .ovf_cnt(a_ovf_cnt)
`endif
  );

  rdata_packer #(.DATA_BUS_WIDTH(64), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .arstn(b_arstn), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .ovf_err(b_ovf_err), .ovf_clr(b_ovf_clr),
    .out_data(b_out_data), .out_keep(b_out_keep), .out_last(b_out_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef RPACK_STATUS_EN
    , .fifo_level(b_fifo_level), .ovf_cnt(b_ovf_cnt)
`endif
  );

  rdata_packer #(.DATA_BUS_WIDTH(16), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .arstn(c_arstn), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_last(c_in_last), .in_ready(c_in_ready), .ovf_err(c_ovf_err), .ovf_clr(c_ovf_clr),
    .out_data(c_out_data), .out_keep(c_out_keep), .out_last(c_out_last),
    .out_valid(c_out_valid), .out_ready(c_out_ready)
`ifdef RPACK_STATUS_EN
    , .fifo_level(c_fifo_level), .ovf_cnt(c_ovf_cnt)
`endif
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- drivers: one half-word per call ----------------
  task automatic a_hw(input logic [15:0] d, input logic l);
    a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
    tick(1);
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic b_hw(input logic [15:0] d, input logic l);
    b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
    tick(1);
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic c_hw(input logic [15:0] d, input logic l);
    c_in_valid = 1'b1; c_in_data = d; c_in_last = l;
    tick(1);
    c_in_valid = 1'b0; c_in_last = 1'b0;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (a_arstn && a_out_valid && a_out_ready) begin
      if (a_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_word: got 0x%0h, required no word", {a_out_last, a_out_keep, a_out_data});
      end else begin
        a_exp = a_exp_q.pop_front();
        check("a_word", {a_out_last, a_out_keep, a_out_data}, a_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (b_arstn && b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_word: got 0x%0h, required no word", {b_out_last, b_out_keep, b_out_data});
      end else begin
        b_exp = b_exp_q.pop_front();
        check("b_word", {b_out_last, b_out_keep, b_out_data}, b_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (c_arstn && c_out_valid && c_out_ready) begin
      if (c_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL c_unexpected_word: got 0x%0h, required no word", {c_out_last, c_out_keep, c_out_data});
      end else begin
        c_exp = c_exp_q.pop_front();
        check("c_word", {c_out_last, c_out_keep, c_out_data}, c_exp);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    a_arstn = 0; a_in_valid = 0; a_in_last = 0; a_in_data = '0; a_ovf_clr = 0; a_out_ready = 0;
    b_arstn = 0; b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_ovf_clr = 0; b_out_ready = 0;
    c_arstn = 0; c_in_valid = 0; c_in_last = 0; c_in_data = '0; c_ovf_clr = 0; c_out_ready = 0;
    drv_done = 0;

    // Reset state
    tick(3);
    check("a_rst_out_valid", a_out_valid, 0);
    check("a_rst_in_ready",  a_in_ready, 1);
    check("a_rst_ovf_err",   a_ovf_err, 0);
    check("a_rst_out_keep",  a_out_keep, 0);
    check("a_rst_out_last",  a_out_last, 0);
    check("b_rst_out_valid", b_out_valid, 0);
    check("b_rst_in_ready",  b_in_ready, 1);
    check("c_rst_out_valid", c_out_valid, 0);
    check("c_rst_in_ready",  c_in_ready, 1);
`ifdef RPACK_STATUS_EN
    check("a_rst_fifo_level", a_fifo_level, 0);
    check("a_rst_ovf_cnt",    a_ovf_cnt, 0);
`endif
    a_arstn = 1; b_arstn = 1; c_arstn = 1;
    tick(2);

    // W=32 basic burst: two full words, 1 clk latency each
    a_out_ready = 1;
    a_exp_q.push_back({1'b0, 2'b11, 32'h2222_1111});
    a_exp_q.push_back({1'b1, 2'b11, 32'h4444_3333});
    a_hw(16'h1111, 1'b0);
    check("a_no_word_after_1st", a_out_valid, 0);
    a_hw(16'h2222, 1'b0);
    check("a_latency_word0", a_out_valid, 1);
    a_hw(16'h3333, 1'b0);
    check("a_popped_word0", a_out_valid, 0);
    a_hw(16'h4444, 1'b1);
    check("a_latency_word1", a_out_valid, 1);
    tick(3);
    check("a_burst_drained", a_exp_q.size(), 0);

    // W=64 partial word: A,B,C with last on C; then a full word and a single-lane word
    b_out_ready = 1;
    b_exp_q.push_back({1'b1, 4'b0111, 64'h0000_CCCC_BBBB_AAAA});
    b_exp_q.push_back({1'b1, 4'b1111, 64'h0004_0003_0002_0001});
    b_exp_q.push_back({1'b1, 4'b0001, 64'h0000_0000_0000_DEAD});
    b_hw(16'hAAAA, 1'b0);
    b_hw(16'hBBBB, 1'b0);
    b_hw(16'hCCCC, 1'b1);
    check("b_latency_partial", b_out_valid, 1);
    check("b_partial_keep", b_out_keep, 4'b0111);
    b_hw(16'h0001, 1'b0);
    b_hw(16'h0002, 1'b0);
    b_hw(16'h0003, 1'b0);
    b_hw(16'h0004, 1'b1);
    b_hw(16'hDEAD, 1'b1);
    tick(3);
    check("b_drained", b_exp_q.size(), 0);

    // W=32 depth 4 overflow: 10 half-words with no consumer
    a_out_ready = 0;
    for (int k = 0; k < 4; k++)
      a_exp_q.push_back({(k == 3), 2'b11, 16'hA001 + 16'(2*k), 16'hA000 + 16'(2*k)});
    for (int i = 0; i < 10; i++) begin
      a_hw(16'hA000 + 16'(i), (i == 7));
      if (i == 6) check("a_ready_before_full", a_in_ready, 1);
      if (i == 7) check("a_ready_after_8th", a_in_ready, 0);
    end
    check("a_ovf_err_set", a_ovf_err, 1);
    check("a_head_stable_keep", a_out_keep, 2'b11);
    check("a_head_stable_data", a_out_data, 32'hA001_A000);
`ifdef RPACK_STATUS_EN
    check("a_ovf_cnt_2", a_ovf_cnt, 2);
    check("a_fifo_level_full", a_fifo_level, 4);
`endif
    tick(2);
    check("a_ovf_err_sticky", a_ovf_err, 1);
    a_out_ready = 1;
    check("a_ready_same_cycle_as_pop", a_in_ready, 0);
    tick(1);
    check("a_ready_after_first_pop", a_in_ready, 1);
    tick(4);
    check("a_ovf_drained", a_exp_q.size(), 0);
    check("a_ovf_empty_valid", a_out_valid, 0);
    a_ovf_clr = 1;
    tick(1);
    a_ovf_clr = 0;
    check("a_ovf_err_cleared", a_ovf_err, 0);
`ifdef RPACK_STATUS_EN
    check("a_ovf_cnt_cleared", a_ovf_cnt, 0);
`endif

    // W=32 stress: fill, then out_ready toggles every cycle; input gated by in_ready
    a_out_ready = 0;
    fork
      begin : stress_drv
        int sent;
        int cyc;
        logic [15:0] d;
        logic [15:0] lo;
        sent = 0; cyc = 0; lo = '0;
        while (sent < 80 && cyc < 2000) begin
          if (a_in_ready) begin
            d = 16'hB000 + 16'(sent);
            a_in_valid = 1'b1; a_in_data = d; a_in_last = ((sent % 8) == 7);
            if ((sent % 2) == 0) lo = d;
            else a_exp_q.push_back({a_in_last, 2'b11, d, lo});
            sent++;
          end else begin
            a_in_valid = 1'b0; a_in_last = 1'b0;
          end
          tick(1);
          cyc++;
        end
        a_in_valid = 1'b0; a_in_last = 1'b0;
        check("a_stress_all_sent", sent, 80);
        drv_done = 1;
      end
      begin : stress_rdy
        int k;
        tick(12);
        k = 0;
        while (!(drv_done && a_exp_q.size() == 0) && k < 3000) begin
          a_out_ready = ~a_out_ready;
          tick(1);
          k++;
        end
        a_out_ready = 1'b0;
        check("a_stress_drain_in_time", (k < 3000), 1);
      end
    join
    check("a_stress_queue_empty", a_exp_q.size(), 0);
    check("a_stress_no_drop", a_ovf_err, 0);
    check("a_stress_fifo_empty", a_out_valid, 0);

    // W=32 reset mid-burst: one buffered word plus one partial lane get discarded
    a_out_ready = 0;
    a_hw(16'h7777, 1'b0);
    a_hw(16'h8888, 1'b1);
    a_hw(16'h9999, 1'b0);
    check("a_pre_reset_valid", a_out_valid, 1);
    a_arstn = 0;
    #1;
    check("a_midrst_out_valid", a_out_valid, 0);
    check("a_midrst_in_ready", a_in_ready, 1);
    check("a_midrst_out_last", a_out_last, 0);
    check("a_midrst_out_keep", a_out_keep, 0);
    tick(1);
    a_arstn = 1;
    tick(1);
    a_out_ready = 1;
    a_exp_q.push_back({1'b1, 2'b11, 32'h6666_5555});
    a_hw(16'h5555, 1'b0);
    check("a_post_rst_no_early_word", a_out_valid, 0);
    a_hw(16'h6666, 1'b1);
    check("a_post_rst_latency", a_out_valid, 1);
    tick(3);
    check("a_post_rst_drained", a_exp_q.size(), 0);

    // W=16: every accept pushes; last mirrored; drop with simultaneous clear
    c_out_ready = 1;
    c_exp_q.push_back({1'b0, 1'b1, 16'h1234});
    c_exp_q.push_back({1'b1, 1'b1, 16'h5678});
    c_exp_q.push_back({1'b0, 1'b1, 16'h9ABC});
    c_hw(16'h1234, 1'b0);
    check("c_latency", c_out_valid, 1);
    c_hw(16'h5678, 1'b1);
    check("c_last_mirror", c_out_last, 1);
    c_hw(16'h9ABC, 1'b0);
    tick(3);
    check("c_drained", c_exp_q.size(), 0);
    c_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      c_exp_q.push_back({(i == 3), 1'b1, 16'hC000 + 16'(i)});
      c_hw(16'hC000 + 16'(i), (i == 3));
    end
    check("c_full_not_ready", c_in_ready, 0);
    c_ovf_clr = 1;
    c_hw(16'hC004, 1'b0);
    c_ovf_clr = 0;
    check("c_set_beats_clear", c_ovf_err, 1);
    c_ovf_clr = 1;
    tick(1);
    c_ovf_clr = 0;
    check("c_clear_alone", c_ovf_err, 0);
`ifdef RPACK_STATUS_EN
    check("c_ovf_cnt_cleared", c_ovf_cnt, 0);
`endif
    c_out_ready = 1;
    tick(6);
    check("c_ovf_drained", c_exp_q.size(), 0);
    check("c_final_empty", c_out_valid, 0);

    check("b_final_queue", b_exp_q.size(), 0);
    check("a_final_queue", a_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
